// File: rtl/fpu_pkg.sv
// Shared FPU definitions: operand field layout, exponent bias, integer saturation
// limits and the operand classes used by the float-to-int converter.
package fpu_pkg;

    localparam int BIAS   = 511;
    localparam int SGN    = 63;
    localparam int EXP_HI = 62;
    localparam int EXP_LO = 53;
    localparam int FRC_HI = 52;

    localparam logic [63:0] INT_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_HALF = 2'd1,
        CLS_NORM = 2'd2
    } cls_e;

    // Two's-complement negation of a 64-bit magnitude.
    function automatic logic [63:0] neg64(input logic [63:0] v);
        return 64'd0 - v;
    endfunction

endpackage

// File: rtl/fpuf2i_shift.sv
// Combinational aligner: places the 54-bit significand into a 64-bit magnitude,
// reporting the first bit lost on right shifts and left shifts past the window.
module fpuf2i_shift (
    input  logic [53:0] sig,
    input  logic        left,
    input  logic [5:0]  amt,
    output logic [63:0] mag,
    output logic        guard,
    output logic        ovf
);

    logic [54:0] rsh_s;

    // Select left or right alignment; an extra LSB catches the guard bit
    always_comb begin
        rsh_s = {sig, 1'b0} >> amt;
        if (left) begin
            mag   = {10'd0, sig} << amt;
            guard = 1'b0;
            ovf   = (amt > 6'd10);
        end else begin
            mag   = {10'd0, rsh_s[54:1]};
            guard = rsh_s[0];
            ovf   = 1'b0;
        end
    end

endmodule

// File: rtl/fpuf2i64.sv
// Three-stage float-to-int64 converter with valid/ready flow control:
// decode, align+round, negate+saturate.
module fpuf2i64 #(
    parameter int BIAS = 511,
    parameter int OUTW = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [63:0]     A,
    input  logic            rnd,
    input  logic            in_vld,
    output logic            in_rdy,
    output logic [OUTW-1:0] res,
    output logic            ovf,
    output logic            out_vld,
    input  logic            out_rdy
);
    import fpu_pkg::*;

    logic s1_vld_r, s2_vld_r, s3_vld_r;
    logic s1_adv_s, s2_adv_s, s3_adv_s;

    logic        s1_sgn_r, s1_rnd_r, s1_left_r;
    cls_e        s1_cls_r;
    logic [53:0] s1_sig_r;
    logic [5:0]  s1_amt_r;

    logic        s2_sgn_r, s2_big_r;
    logic [63:0] s2_mag_r;

    logic signed [10:0] k_s;
    cls_e        cls_s;
    logic        left_s;
    logic [5:0]  amt_s;

    logic [63:0] sh_mag_s, mag_s, res_s;
    logic        sh_guard_s, sh_ovf_s, big_s, ovf_s;

    assign s3_adv_s = !s3_vld_r || out_rdy;
    assign s2_adv_s = !s2_vld_r || s3_adv_s;
    assign s1_adv_s = !s1_vld_r || s2_adv_s;
    assign in_rdy   = s1_adv_s;
    assign out_vld  = s3_vld_r;

    // Classify the operand and plan the alignment shift from the unbiased exponent
    always_comb begin
        k_s    = $signed({1'b0, A[EXP_HI:EXP_LO]}) - $signed(11'(BIAS));
        cls_s  = CLS_NORM;
        left_s = 1'b0;
        amt_s  = 6'd0;
        if (A[EXP_HI:EXP_LO] == 10'd0 || k_s < -11'sd1) begin
            cls_s = CLS_ZERO;
        end else if (k_s == -11'sd1) begin
            cls_s = CLS_HALF;
        end else if (k_s <= 11'sd53) begin
            amt_s = 6'(11'sd53 - k_s);
        end else if (k_s <= 11'sd63) begin
            left_s = 1'b1;
            amt_s  = 6'(k_s - 11'sd53);
        end else begin
            // Any shift beyond 10 overflows; clamp so the aligner flags it
            left_s = 1'b1;
            amt_s  = 6'd11;
        end
    end

    // Stage valid bits; reset discards everything in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_r <= 1'b0;
            s2_vld_r <= 1'b0;
        end else begin
            if (s1_adv_s) s1_vld_r <= in_vld;
            if (s2_adv_s) s2_vld_r <= s1_vld_r;
        end
    end

    // Stage 1 payload
    always_ff @(posedge clk) begin
        if (s1_adv_s && in_vld) begin
            s1_sgn_r  <= A[SGN];
            s1_rnd_r  <= rnd;
            s1_cls_r  <= cls_s;
            s1_sig_r  <= {1'b1, A[FRC_HI:0]};
            s1_left_r <= left_s;
            s1_amt_r  <= amt_s;
        end
    end

    fpuf2i_shift u_shift (
        .sig   (s1_sig_r),
        .left  (s1_left_r),
        .amt   (s1_amt_r),
        .mag   (sh_mag_s),
        .guard (sh_guard_s),
        .ovf   (sh_ovf_s)
    );

    // Round the aligned magnitude; the half class rounds to 1 only when rounding
    always_comb begin
        case (s1_cls_r)
            CLS_ZERO: mag_s = 64'd0;
            CLS_HALF: mag_s = {63'd0, s1_rnd_r};
            CLS_NORM: mag_s = sh_mag_s + {63'd0, s1_rnd_r & sh_guard_s};
            default:  mag_s = 64'd0;
        endcase
        big_s = (s1_cls_r == CLS_NORM) && sh_ovf_s;
    end

    // Stage 2 payload
    always_ff @(posedge clk) begin
        if (s2_adv_s && s1_vld_r) begin
            s2_sgn_r <= s1_sgn_r;
            s2_mag_r <= mag_s;
            s2_big_r <= big_s;
        end
    end

    // Apply sign; magnitudes at or above 2^63 saturate, except exactly -2^63
    always_comb begin
        if (s2_big_r || s2_mag_r[63]) begin
            if (s2_sgn_r && !s2_big_r && s2_mag_r == INT_MIN) begin
                res_s = INT_MIN;
                ovf_s = 1'b0;
            end else if (s2_sgn_r) begin
                res_s = INT_MIN;
                ovf_s = 1'b1;
            end else begin
                res_s = INT_MAX;
                ovf_s = 1'b1;
            end
        end else begin
            res_s = s2_sgn_r ? neg64(s2_mag_r) : s2_mag_r;
            ovf_s = 1'b0;
        end
    end

    // Output stage: held while the consumer stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s3_vld_r <= 1'b0;
            res      <= 64'd0;
            ovf      <= 1'b0;
        end else if (s3_adv_s) begin
            s3_vld_r <= s2_vld_r;
            if (s2_vld_r) begin
                res <= res_s;
                ovf <= ovf_s;
            end
        end
    end

endmodule
